i2s_frame_tx: RTL and testbench
===============================

# i2s_frame_tx

Parametrised, synthesisable I2S/TDM serial audio transmitter. It generates the bit clock (AUD_BCLK) and the frame clock (AUD_LRC) from MCLK, and serialises parallel multi-channel frames onto AUD_ADC_DATA, MSB first. It drives the audio receive path of topLevel from on-chip data, for hardware loopback and self-test, and generalises the fixed 2-channel, 24-in-32 bitstream to configurable sample width, slot width, channel count and framing mode. Frames are supplied through a valid/ready handshake with one frame of buffering.

## Interface
- SAMPLE_W, 24: bits per sample. Must satisfy 1 ≤ SAMPLE_W ≤ SLOT_W − MODE_I2S.
- SLOT_W, 32: BCLK periods per channel slot.
- CHANNELS, 2: slots per frame, ≥ 2.
  - CHANNELS == 2: LRC is a level signal.
  - CHANNELS > 2: TDM; LRC is a frame-sync pulse.
- BCLK_HALF, 16: MCLK cycles per BCLK half-period, ≥ 2.
- MODE_I2S, 1: 1 = I2S, data delayed one BCLK after the slot boundary; 0 = left-justified.
- MCLK  in  1  sole clock; all state on posedge.
- RESET  in  1  asynchronous, active-high reset.
- enable  in  1  when 0, the BCLK divider and bit counter hold at their current values.
- sample_in  in  CHANNELS*SAMPLE_W  frame. Channel c occupies [(c+1)*SAMPLE_W−1 : c*SAMPLE_W].
- sample_valid  in  1  frame offered.
- sample_ready  out  1  pending buffer empty. Accept occurs when valid && ready.
- AUD_BCLK  out  1  bit clock, registered.
- AUD_LRC  out  1  frame clock / frame sync, registered.
- AUD_ADC_DATA  out  1  serial data, registered.
- frame_start  out  1  one-MCLK pulse when a new frame is loaded into the shift stage.
- underrun  out  1  one-MCLK pulse when a frame boundary finds the pending buffer empty.

## Operation
- **Storage.** Two stages:
  - pending register plus pending_full flag;
  - active register holding the frame currently being serialised.
- **Divider.** div_cnt counts 0..BCLK_HALF−1 and wraps. On each wrap AUD_BCLK toggles.
  - A wrap that drives BCLK 1→0 is a *fall event*; all serial outputs update only on fall events.
- **Bit position.** pos counts 0..SLOT_W*CHANNELS−1 and advances on each fall event.
  - slot = pos / SLOT_W; p = pos mod SLOT_W.
- **Frame boundary.** The fall event at which pos becomes 0.
  - If pending_full: active ← pending, pending_full ← 0, pulse frame_start.
  - Else: active ← all zeros, pulse frame_start and underrun.
- **Data bit.** k = p − MODE_I2S.
  - If 0 ≤ k < SAMPLE_W: AUD_ADC_DATA = active channel slot, bit SAMPLE_W−1−k.
  - Otherwise 0 (padding / delay bit).
- **LRC, CHANNELS == 2:** AUD_LRC = (slot == 1). Channel 0 is sent with LRC low.
- **LRC, CHANNELS > 2:** AUD_LRC = 1 only while pos == 0, otherwise 0.
- **Handshake.**
  - sample_ready = !pending_full.
  - An accept sets pending ← sample_in and pending_full ← 1.
- **Simultaneous accept and boundary in one MCLK cycle:**
  - active takes the old pending contents;
  - pending takes sample_in;
  - pending_full stays 1.
  - Because ready was 1, the old pending was empty, so active ← zeros and underrun pulses.
- **Disabled.** enable = 0 freezes div_cnt, BCLK, LRC, DATA and pos. The handshake still operates.

## Timing
- **Reset values.**
  - Outputs: AUD_BCLK=0, AUD_LRC=0, AUD_ADC_DATA=0, sample_ready=1, frame_start=0, underrun=0.
  - Internal: div_cnt=0, pending_full=0, active=0.
  - pos is initialised to SLOT_W*CHANNELS−1, so the first fall event is a frame boundary.
- **After release, with enable=1:**
  - BCLK first rises on the BCLK_HALF-th MCLK edge.
  - BCLK first falls on the 2*BCLK_HALF-th edge. This is frame boundary 0.
- **BCLK** has period 2*BCLK_HALF MCLK cycles and 50 % duty.
- **Alignment.** DATA and LRC change in the same MCLK cycle as the BCLK falling edge. They are stable across the following rising edge, which is where the receiver samples.
- **Latency.** A frame accepted at least one MCLK cycle before boundary N has its first data bit at boundary N (LJ) or at the next fall event (I2S).
- **Throughput.** One frame per SLOT_W*CHANNELS*2*BCLK_HALF MCLK cycles.
- **Reset mid-frame.** Asynchronously returns every register to its reset value. The partial frame and any pending frame are discarded; no pulse is emitted.

## Test plan
- **Basic I2S stream.** Defaults; accept frame L=0xABCDEF, R=0x123456 before boundary 0.
  - Sampled on BCLK rise: LRC low for 32 bits, with bit 0 = 0, bits 1..24 = 0xABCDEF MSB first, then 7 zeros.
  - Then LRC high with 0x123456 in the same layout.
  - frame_start pulses once; underrun does not pulse.
- **Back-pressure.** Hold sample_valid high with frames F1, F2, F3.
  - sample_ready drops after F1 is accepted and returns high one cycle after each boundary.
  - Frames appear in order F1, F2, F3 with none lost or duplicated.
- **Underrun.** Accept a single frame, then stop.
  - The following boundary pulses underrun and emits an all-zero frame.
  - A frame accepted later resumes at the next boundary.
- **Left-justified, reduced width.** MODE_I2S=0, SAMPLE_W=16, SLOT_W=16; L=0x8001, R=0x7FFE.
  - The MSB appears at p=0 with no padding.
  - LRC toggles every 16 BCLK.
- **TDM.** CHANNELS=4, SLOT_W=32; channels 0x000001, 0x000002, 0x000003, 0x000004.
  - LRC is high only during the first BCLK of each 128-BCLK frame.
  - Slots carry the values in channel order.
- **Reset and enable.** Assert RESET at pos=40.
  - All outputs are 0 and sample_ready=1 immediately, without waiting for an MCLK edge.
  - After release, the first fall event occurs 2*BCLK_HALF MCLK cycles later.
  - enable=0 for 100 cycles freezes BCLK, LRC and DATA at their current levels.

Source files
------------

// File: rtl/i2s_frame_tx.sv
// ---------------------------------------------------------------------------
// i2s_frame_tx
//
// I2S / left-justified / TDM serial audio transmitter. Derives the bit clock
// and frame clock from MCLK and shifts multi-channel frames out MSB first.
// Frames arrive through a valid/ready handshake into a one-deep pending
// buffer. At each frame boundary the buffer moves into the active (shifting)
// stage. An empty buffer at a boundary sends an all-zero frame instead.
//
// Parameters
//   SAMPLE_W  : bits per sample (1 .. SLOT_W - MODE_I2S)
//   SLOT_W    : BCLK periods per channel slot
//   CHANNELS  : slots per frame (2 = level LRC, >2 = TDM frame-sync pulse)
//   BCLK_HALF : MCLK cycles per BCLK half period (>= 2)
//   MODE_I2S  : 1 = data delayed one BCLK after slot start, 0 = left-justified
//
// Ports
//   MCLK          in   master clock, all state on its rising edge
//   RESET         in   asynchronous active-high reset
//   enable        in   0 freezes divider, bit position and serial outputs
//   sample_in     in   frame, channel c at [(c+1)*SAMPLE_W-1 : c*SAMPLE_W]
//   sample_valid  in   frame offered
//   sample_ready  out  pending buffer empty (accept = valid && ready)
//   AUD_BCLK      out  bit clock
//   AUD_LRC       out  frame clock (2 ch) or frame-sync pulse (TDM)
//   AUD_ADC_DATA  out  serial data, changes on BCLK falling edges
//   frame_start   out  one-cycle pulse when a frame enters the shift stage
//   underrun      out  one-cycle pulse when a boundary finds no pending frame
// ---------------------------------------------------------------------------
module i2s_frame_tx #(
  parameter int SAMPLE_W  = 24,
  parameter int SLOT_W    = 32,
  parameter int CHANNELS  = 2,
  parameter int BCLK_HALF = 16,
  parameter int MODE_I2S  = 1
) (
  input  logic                         MCLK,
  input  logic                         RESET,
  input  logic                         enable,
  input  logic [CHANNELS*SAMPLE_W-1:0] sample_in,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  output logic                         AUD_BCLK,
  output logic                         AUD_LRC,
  output logic                         AUD_ADC_DATA,
  output logic                         frame_start,
  output logic                         underrun
);

  localparam int FRAME_W = CHANNELS * SAMPLE_W;
  localparam int DIV_W   = $clog2(BCLK_HALF);
  localparam int BIT_W   = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam int CH_W    = $clog2(CHANNELS);
  localparam int SMP_W   = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_W - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
  // Window of slot bit positions that carry sample bits: [K_LO, K_HI).
  // One extra bit of width so K_HI == SLOT_W still fits.
  localparam logic [BIT_W:0]   K_LO     = (BIT_W + 1)'(MODE_I2S);
  localparam logic [BIT_W:0]   K_HI     = (BIT_W + 1)'(MODE_I2S + SAMPLE_W);
  localparam logic [SMP_W-1:0] SMP_MSB  = SMP_W'(SAMPLE_W - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0]   div_cnt_reg;
  logic               bclk_reg;
  // Bit position is held as (slot, bit-in-slot) so no divide is needed.
  logic [BIT_W-1:0]   bit_reg;
  logic [CH_W-1:0]    slot_reg;
  logic               lrc_reg;
  logic               data_reg;
  logic [FRAME_W-1:0] pending_reg;
  logic               pending_full_reg;
  logic [FRAME_W-1:0] active_reg;
  logic               frame_start_reg;
  logic               underrun_reg;

  // -------------------------------------------------------------------------
  // Next-state decode
  // -------------------------------------------------------------------------
  logic               wrap;
  logic               fall;
  logic               boundary;
  logic               accept;
  logic [BIT_W-1:0]   bit_next;
  logic [CH_W-1:0]    slot_next;
  logic [FRAME_W-1:0] active_load;
  logic [FRAME_W-1:0] active_next;
  logic [BIT_W:0]     bit_ext;
  logic [BIT_W:0]     k_off;
  logic [SMP_W-1:0]   smp_idx;
  logic               in_sample;
  logic               data_next;
  logic               lrc_next;

  always_comb begin
    wrap        = enable && (div_cnt_reg == DIV_LAST);
    // Only the wrap that takes BCLK from 1 to 0 moves the serial outputs.
    fall        = wrap && bclk_reg;
    boundary    = fall && (bit_reg == BIT_LAST) && (slot_reg == CH_LAST);
    accept      = sample_valid && !pending_full_reg;

    bit_next    = bit_reg;
    slot_next   = slot_reg;
    if (bit_reg == BIT_LAST) begin
      bit_next  = '0;
      slot_next = (slot_reg == CH_LAST) ? '0 : slot_reg + 1'b1;
    end else begin
      bit_next  = bit_reg + 1'b1;
    end

    // The old pending contents move to active. If the buffer was empty the
    // slot is filled with silence. A same-cycle accept therefore never
    // reaches active directly; it waits in pending for the next boundary.
    active_load = pending_full_reg ? pending_reg : '0;
    // The first bit of a frame (left-justified MSB) comes from the frame
    // being loaded, so the data mux looks at the post-boundary value.
    active_next = boundary ? active_load : active_reg;
  end

  // Split the frame into per-channel samples for the data mux.
  logic [SAMPLE_W-1:0] chan [CHANNELS];

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign chan[gi] = active_next[gi*SAMPLE_W +: SAMPLE_W];
    end
  endgenerate

  always_comb begin
    bit_ext   = {1'b0, bit_next};
    in_sample = (bit_ext >= K_LO) && (bit_ext < K_HI);
    k_off     = bit_ext - K_LO;
    smp_idx   = SMP_MSB - k_off[SMP_W-1:0];
    data_next = 1'b0;
    if (in_sample) begin
      data_next = chan[slot_next][smp_idx];
    end
  end

  generate
    if (CHANNELS == 2) begin : g_lrc_level
      // Channel 0 goes out with LRC low, channel 1 with LRC high.
      assign lrc_next = (slot_next == CH_W'(1));
    end else begin : g_lrc_sync
      // TDM: one-BCLK frame-sync pulse on the first bit of the frame.
      assign lrc_next = (slot_next == '0) && (bit_next == '0);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      div_cnt_reg      <= '0;
      bclk_reg         <= 1'b0;
      // Parked on the last position so the first fall event is a boundary.
      bit_reg          <= BIT_LAST;
      slot_reg         <= CH_LAST;
      lrc_reg          <= 1'b0;
      data_reg         <= 1'b0;
      pending_reg      <= '0;
      pending_full_reg <= 1'b0;
      active_reg       <= '0;
      frame_start_reg  <= 1'b0;
      underrun_reg     <= 1'b0;
    end else begin
      frame_start_reg <= boundary;
      underrun_reg    <= boundary && !pending_full_reg;

      if (wrap) begin
        div_cnt_reg <= '0;
        bclk_reg    <= ~bclk_reg;
      end else if (enable) begin
        div_cnt_reg <= div_cnt_reg + 1'b1;
      end

      if (fall) begin
        bit_reg  <= bit_next;
        slot_reg <= slot_next;
        lrc_reg  <= lrc_next;
        data_reg <= data_next;
      end

      if (boundary) begin
        active_reg <= active_load;
      end

      if (accept) begin
        pending_reg      <= sample_in;
        pending_full_reg <= 1'b1;
      end else if (boundary) begin
        pending_full_reg <= 1'b0;
      end
    end
  end

  assign sample_ready = !pending_full_reg;
  assign AUD_BCLK     = bclk_reg;
  assign AUD_LRC      = lrc_reg;
  assign AUD_ADC_DATA = data_reg;
  assign frame_start  = frame_start_reg;
  assign underrun     = underrun_reg;

endmodule

// File: tb/tb_i2s_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_frame_tx
//
// Three transmitters share MCLK, RESET and enable:
//   dut0 : default I2S, 2 x 24-in-32, BCLK_HALF=16
//   dut1 : left-justified, 2 x 16-in-16, BCLK_HALF=2
//   dut2 : TDM, 4 x 24-in-32, I2S delay, BCLK_HALF=2
// A receiver task samples DATA/LRC on each BCLK rise and assembles a frame.
// ---------------------------------------------------------------------------
module tb_i2s_frame_tx;

  logic MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  logic rst;
  logic en;

  logic [47:0] in0;
  logic        v0, r0, b0, l0, d0, fs0, ur0;
  logic [31:0] in1;
  logic        v1, r1, b1, l1, d1, fs1, ur1;
  logic [95:0] in2;
  logic        v2, r2, b2, l2, d2, fs2, ur2;

  i2s_frame_tx dut0 (
    .MCLK(MCLK), .RESET(rst), .enable(en),
    .sample_in(in0), .sample_valid(v0), .sample_ready(r0),
    .AUD_BCLK(b0), .AUD_LRC(l0), .AUD_ADC_DATA(d0),
    .frame_start(fs0), .underrun(ur0)
  );

  i2s_frame_tx #(
    .SAMPLE_W(16), .SLOT_W(16), .CHANNELS(2), .BCLK_HALF(2), .MODE_I2S(0)
  ) dut1 (
    .MCLK(MCLK), .RESET(rst), .enable(en),
    .sample_in(in1), .sample_valid(v1), .sample_ready(r1),
    .AUD_BCLK(b1), .AUD_LRC(l1), .AUD_ADC_DATA(d1),
    .frame_start(fs1), .underrun(ur1)
  );

  i2s_frame_tx #(
    .SAMPLE_W(24), .SLOT_W(32), .CHANNELS(4), .BCLK_HALF(2), .MODE_I2S(1)
  ) dut2 (
    .MCLK(MCLK), .RESET(rst), .enable(en),
    .sample_in(in2), .sample_valid(v2), .sample_ready(r2),
    .AUD_BCLK(b2), .AUD_LRC(l2), .AUD_ADC_DATA(d2),
    .frame_start(fs2), .underrun(ur2)
  );

  // Observation mux: tasks look at whichever DUT sel points to.
  int   sel;
  logic obs_bclk, obs_lrc, obs_data, obs_fs, obs_ur, obs_ready;

  always_comb begin
    case (sel)
      0: begin
        obs_bclk = b0; obs_lrc = l0; obs_data = d0;
        obs_fs = fs0; obs_ur = ur0; obs_ready = r0;
      end
      1: begin
        obs_bclk = b1; obs_lrc = l1; obs_data = d1;
        obs_fs = fs1; obs_ur = ur1; obs_ready = r1;
      end
      default: begin
        obs_bclk = b2; obs_lrc = l2; obs_data = d2;
        obs_fs = fs2; obs_ur = ur2; obs_ready = r2;
      end
    endcase
  end

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [63:0] exp_bits;
  } vec_t;

  vec_t vecs [4];

  localparam logic [63:0] LRC_2CH = 64'h00000000_FFFFFFFF;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %h", name, act);
    end
  endtask

  task automatic drive(input int s, input logic [127:0] f, input logic v);
    case (s)
      0:       begin in0 = f[47:0]; v0 = v; end
      1:       begin in1 = f[31:0]; v1 = v; end
      default: begin in2 = f[95:0]; v2 = v; end
    endcase
  endtask

  // Offer a frame and hold valid until it is accepted (bounded).
  task automatic feed(input int s, input logic [127:0] f);
    int   g;
    logic rdy;
    g = 0;
    drive(s, f, 1'b1);
    do begin
      rdy = obs_ready;
      @(posedge MCLK); #1;
      g++;
    end while (!rdy && g < 5000);
    drive(s, f, 1'b0);
    check("accept", 128'(rdy), 128'(1));
    check("ready_drop", 128'(obs_ready), 128'(0));
  endtask

  // Receive one frame of nbits, sampling on BCLK rises. With wait_fs the
  // task first waits for the next frame_start; otherwise the caller is
  // positioned on the boundary sample already.
  task automatic collect(input int nbits, input bit wait_fs,
                         output logic [127:0] d, output logic [127:0] l,
                         output logic ur, output logic rdy, output int extra);
    int   g;
    int   i;
    logic prev;
    d = '0; l = '0; ur = 1'b0; rdy = 1'b0; extra = 0; g = 0; i = 0;
    if (wait_fs) begin
      do begin
        @(posedge MCLK); #1;
        g++;
      end while (!obs_fs && g < 10000);
      if (!obs_fs) begin
        tests++;
        fails++;
        $display("FAIL fs_timeout: frame_start=0 after %0d cycles, expected 1", g);
        return;
      end
    end
    ur   = obs_ur;
    rdy  = obs_ready;
    prev = obs_bclk;
    while (i < nbits && g < 20000) begin
      @(posedge MCLK); #1;
      g++;
      if (obs_fs) extra++;
      if (!prev && obs_bclk) begin
        d = {d[126:0], obs_data};
        l = {l[126:0], obs_lrc};
        i++;
      end
      prev = obs_bclk;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] cd, cl;
    logic         cur, crdy, prev;
    int           cex, cnt, rise_at, fall_at, nf, changes, g;
    logic         fb, fl, fdt;

    // {L, R, expected 64-bit stream}: each slot is 0, 24 sample bits, 7 zeros.
    vecs[0] = '{24'hABCDEF, 24'h123456, 64'h55E6F780_091A2B00};
    vecs[1] = '{24'hFFFFFF, 24'h000001, 64'h7FFFFF80_00000080};
    vecs[2] = '{24'h800000, 24'hC3A55A, 64'h40000000_61D2AD00};
    vecs[3] = '{24'h5A5A5A, 24'hA5A5A5, 64'h2D2D2D00_52D2D280};

    rst = 1'b1; en = 1'b1; sel = 0;
    in0 = '0; in1 = '0; in2 = '0; v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    repeat (3) @(posedge MCLK);
    #1;

    // ---- reset state ----
    check("rst_bclk",  128'(b0),  128'(0));
    check("rst_lrc",   128'(l0),  128'(0));
    check("rst_data",  128'(d0),  128'(0));
    check("rst_ready", 128'(r0),  128'(1));
    check("rst_fs",    128'(fs0), 128'(0));
    check("rst_ur",    128'(ur0), 128'(0));

    // ---- basic I2S frame, accepted on the first edge after release ----
    in0 = {vecs[0].r, vecs[0].l};
    v0  = 1'b1;
    rst = 1'b0;
    cnt = 0; rise_at = 0; fall_at = 0; prev = b0;
    while (fall_at == 0 && cnt < 200) begin
      @(posedge MCLK); #1;
      cnt++;
      if (cnt == 1) begin
        check("first_accept_ready", 128'(r0), 128'(0));
        v0 = 1'b0;
      end
      if (!prev && b0 && rise_at == 0) rise_at = cnt;
      if (prev && !b0) fall_at = cnt;
      prev = b0;
    end
    check("first_rise_edge", 128'(rise_at), 128'(16));
    check("first_fall_edge", 128'(fall_at), 128'(32));
    check("b0_frame_start",  128'(fs0), 128'(1));
    check("b0_underrun",     128'(ur0), 128'(0));
    check("b0_ready",        128'(r0),  128'(1));
    collect(64, 1'b0, cd, cl, cur, crdy, cex);
    check("basic_data",  cd, 128'(vecs[0].exp_bits));
    check("basic_lrc",   cl, 128'(LRC_2CH));
    check("basic_extra_fs", 128'(cex), 128'(0));

    // ---- back-pressure: table frames streamed with valid held high ----
    fork
      begin
        for (int i = 1; i < 4; i++) begin
          feed(0, {80'b0, vecs[i].r, vecs[i].l});
        end
      end
      begin
        logic [127:0] td, tl;
        logic         tur, trdy;
        int           tex;
        for (int j = 1; j < 4; j++) begin
          collect(64, 1'b1, td, tl, tur, trdy, tex);
          check($sformatf("vec%0d_data", j), td, 128'(vecs[j].exp_bits));
          check($sformatf("vec%0d_lrc", j), tl, 128'(LRC_2CH));
          check($sformatf("vec%0d_underrun", j), 128'(tur), 128'(0));
          check($sformatf("vec%0d_ready_at_fs", j), 128'(trdy), 128'(1));
          check($sformatf("vec%0d_extra_fs", j), 128'(tex), 128'(0));
        end
      end
    join

    // ---- underrun, then resume ----
    collect(64, 1'b1, cd, cl, cur, crdy, cex);
    check("ur_pulse", 128'(cur), 128'(1));
    check("ur_zero_data", cd, 128'(0));
    check("ur_lrc", cl, 128'(LRC_2CH));
    feed(0, {80'b0, vecs[0].r, vecs[0].l});
    collect(64, 1'b1, cd, cl, cur, crdy, cex);
    check("resume_data", cd, 128'(vecs[0].exp_bits));
    check("resume_underrun", 128'(cur), 128'(0));

    // ---- asynchronous reset at pos=40 with a frame pending ----
    feed(0, {80'b0, 24'hFFFFFF, 24'h000000});
    g = 0;
    do begin @(posedge MCLK); #1; g++; end while (!fs0 && g < 5000);
    feed(0, {80'b0, vecs[3].r, vecs[3].l});
    nf = 0; g = 0; prev = b0;
    while (nf < 40 && g < 5000) begin
      @(posedge MCLK); #1;
      g++;
      if (prev && !b0) nf++;
      prev = b0;
    end
    repeat (20) @(posedge MCLK);
    #1;
    check("pre_rst_bclk",  128'(b0), 128'(1));
    check("pre_rst_lrc",   128'(l0), 128'(1));
    check("pre_rst_data",  128'(d0), 128'(1));
    check("pre_rst_ready", 128'(r0), 128'(0));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_bclk",  128'(b0), 128'(0));
    check("async_rst_lrc",   128'(l0), 128'(0));
    check("async_rst_data",  128'(d0), 128'(0));
    check("async_rst_ready", 128'(r0), 128'(1));
    @(posedge MCLK); #1;
    rst = 1'b0;
    cnt = 0;
    do begin @(posedge MCLK); #1; cnt++; end while (!fs0 && cnt < 200);
    check("post_rst_first_fall", 128'(cnt), 128'(32));
    check("post_rst_underrun", 128'(ur0), 128'(1));

    // ---- enable=0 freezes the serial side, handshake keeps working ----
    g = 0;
    do begin @(posedge MCLK); #1; g++; end while (!b0 && g < 200);
    en = 1'b0;
    fb = b0; fl = l0; fdt = d0;
    feed(0, {80'b0, vecs[1].r, vecs[1].l});
    changes = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge MCLK); #1;
      if (b0 !== fb || l0 !== fl || d0 !== fdt || fs0 !== 1'b0) changes++;
    end
    check("freeze_changes", 128'(changes), 128'(0));
    check("freeze_bclk_high", 128'(b0), 128'(1));
    en = 1'b1;
    cnt = 0;
    do begin @(posedge MCLK); #1; cnt++; end while (b0 && cnt < 200);
    check("resume_half_period", 128'(cnt), 128'(16));

    // ---- left-justified: accept coinciding with a boundary ----
    sel = 1;
    g = 0;
    do begin @(posedge MCLK); #1; g++; end while (!fs1 && g < 1000);
    repeat (127) @(posedge MCLK);
    #1;
    drive(1, {96'b0, 16'h7FFE, 16'h8001}, 1'b1);
    @(posedge MCLK); #1;
    drive(1, {96'b0, 16'h7FFE, 16'h8001}, 1'b0);
    check("sim_frame_start", 128'(fs1), 128'(1));
    check("sim_underrun",    128'(ur1), 128'(1));
    check("sim_ready",       128'(r1),  128'(0));
    collect(32, 1'b1, cd, cl, cur, crdy, cex);
    check("lj_data", cd, 128'(32'h8001_7FFE));
    check("lj_lrc",  cl, 128'(32'h0000_FFFF));
    check("lj_underrun", 128'(cur), 128'(0));

    // ---- TDM, 4 channels ----
    sel = 2;
    g = 0;
    do begin @(posedge MCLK); #1; g++; end while (!fs2 && g < 2000);
    feed(2, {32'b0, 24'h000004, 24'h000003, 24'h000002, 24'h000001});
    collect(128, 1'b1, cd, cl, cur, crdy, cex);
    check("tdm_data", cd, 128'h00000080_00000100_00000180_00000200);
    check("tdm_lrc",  cl, 128'h80000000_00000000_00000000_00000000);
    check("tdm_underrun", 128'(cur), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
